// File: rtl/ex_mem_muldiv.sv
// ============================================================================
// ex_mem_muldiv
// ----------------------------------------------------------------------------
// EX/MEM pipeline latch for the MIPS pipeline. It adds an iterative unsigned
// multiply/divide unit beside the single-cycle ALU path.
//
// Single-cycle ALU results go through the latch with one cycle of latency.
// MULTU, DIVU and REMU each take LEN_DATA iterations. While one of them runs,
// `stall` holds the upstream stages and bubbles are sent toward MEM.
//
// Whenever out_valid is low, every out_* field is driven to zero. A bubble
// therefore never carries stale data or stale control.
//
// Parameters
//   LEN_DATA     datapath width (even, >= 4)
//   NUM_BITS     register-address width
//   LEN_WB_BUS   write-back control bus width
//   LEN_MEM_BUS  memory control bus width
//
// Ports
//   clk              clock, all state changes on the rising edge
//   reset            synchronous, active-high reset
//   in_valid         an instruction is present in EX this cycle
//   in_md_op         00 pass ALU, 01 MULTU low half, 10 DIVU quotient,
//                    11 REMU remainder
//   in_alu_result    single-cycle ALU result
//   in_a / in_b      mul/div operands (dividend/multiplicand, divisor/multiplier)
//   in_write_reg     destination register
//   in_reg2          store data
//   in_mem_bus       memory control
//   in_wb_bus        write-back control
//   flush            kill the instruction in EX, or abort a running mul/div
//   stall            high exactly while the unit is BUSY
//   out_valid        the output registers hold a valid instruction
//   out_result       ALU or mul/div result
//   out_reg2         latched store data
//   out_write_reg    latched destination register
//   out_mem_bus      latched memory control
//   out_wb_bus       latched write-back control
//   out_busy_cycles  saturating count of stall cycles since reset
// ============================================================================
module ex_mem_muldiv #(
   parameter int LEN_DATA    = 32,
   parameter int NUM_BITS    = 5,
   parameter int LEN_WB_BUS  = 2,
   parameter int LEN_MEM_BUS = 9
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [1:0]             in_md_op,
   input  logic [LEN_DATA-1:0]    in_alu_result,
   input  logic [LEN_DATA-1:0]    in_a,
   input  logic [LEN_DATA-1:0]    in_b,
   input  logic [NUM_BITS-1:0]    in_write_reg,
   input  logic [LEN_DATA-1:0]    in_reg2,
   input  logic [LEN_MEM_BUS-1:0] in_mem_bus,
   input  logic [LEN_WB_BUS-1:0]  in_wb_bus,
   input  logic                   flush,
   output logic                   stall,
   output logic                   out_valid,
   output logic [LEN_DATA-1:0]    out_result,
   output logic [LEN_DATA-1:0]    out_reg2,
   output logic [NUM_BITS-1:0]    out_write_reg,
   output logic [LEN_MEM_BUS-1:0] out_mem_bus,
   output logic [LEN_WB_BUS-1:0]  out_wb_bus,
   output logic [15:0]            out_busy_cycles
);

   localparam int CNT_W = $clog2(LEN_DATA + 1);

   localparam logic [1:0] OP_PASS = 2'b00;
   localparam logic [1:0] OP_MULU = 2'b01;
   localparam logic [1:0] OP_DIVU = 2'b10;
   localparam logic [1:0] OP_REMU = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic [CNT_W-1:0]       count;
   logic [1:0]             op_q;

   // Shared iteration registers. The multiplier and the divider use them in
   // different roles.
   //   acc_q : running product (MULTU) or partial remainder (DIVU/REMU)
   //   opa_q : multiplicand shifted left (MULTU), or dividend bits shifted
   //           out while quotient bits shift in (DIVU/REMU)
   //   opb_q : multiplier shifted right (MULTU) or fixed divisor (DIVU/REMU)
   logic [LEN_DATA-1:0]    acc_q;
   logic [LEN_DATA-1:0]    opa_q;
   logic [LEN_DATA-1:0]    opb_q;

   logic [NUM_BITS-1:0]    write_reg_q;
   logic [LEN_DATA-1:0]    reg2_q;
   logic [LEN_MEM_BUS-1:0] mem_bus_q;
   logic [LEN_WB_BUS-1:0]  wb_bus_q;

   logic [LEN_DATA-1:0]    mul_acc_next;
   logic [LEN_DATA:0]      rem_shift;
   logic [LEN_DATA:0]      rem_diff;
   logic                   div_fits;
   logic [LEN_DATA-1:0]    rem_next;
   logic [LEN_DATA-1:0]    quo_next;
   logic [LEN_DATA-1:0]    final_result;
   logic                   last_iter;
   logic                   accept;

   assign stall     = (state == BUSY);
   assign last_iter = (count == CNT_W'(1));
   assign accept    = in_valid && !flush;

   // One step of shift-add multiplication and one step of restoring division.
   // Both are computed every cycle, and op_q selects which one is kept.
   //
   // For division, the partial remainder is shifted left and takes in the next
   // dividend bit. The bench then tries to subtract the divisor. The extra top
   // bit of rem_diff is a borrow flag, so "fits" means no borrow happened.
   //
   // A zero divisor always fits. This naturally produces an all-ones quotient
   // and a remainder equal to the dividend.
   always_comb begin
      mul_acc_next = opb_q[0] ? (acc_q + opa_q) : acc_q;
      rem_shift    = {acc_q, opa_q[LEN_DATA-1]};
      rem_diff     = rem_shift - {1'b0, opb_q};
      div_fits     = ~rem_diff[LEN_DATA];
      rem_next     = div_fits ? rem_diff[LEN_DATA-1:0] : rem_shift[LEN_DATA-1:0];
      quo_next     = {opa_q[LEN_DATA-2:0], div_fits};
      case (op_q)
         OP_MULU: final_result = mul_acc_next;
         OP_DIVU: final_result = quo_next;
         OP_REMU: final_result = rem_next;
         default: final_result = '0;
      endcase
   end

   // State register. Reset wins over everything else.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   // A mul/div op that is accepted in IDLE enters BUSY. BUSY ends when the
   // last iteration completes, or at once on a flush.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept && (in_md_op != OP_PASS)) begin
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (flush || last_iter) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath and output latch.
   //
   // Every cycle starts from an all-zero bubble on the outputs. Two cases
   // override it:
   //   - an accepted pass-through instruction, written in IDLE;
   //   - the last iteration of a mul/div, written in BUSY.
   //
   // A mul/div op is captured whole on its accept edge: the operands and the
   // fields it must later write back. This is needed because upstream may
   // change the inputs once the op has left EX.
   always_ff @(posedge clk) begin
      if (reset) begin
         count         <= '0;
         op_q          <= OP_PASS;
         acc_q         <= '0;
         opa_q         <= '0;
         opb_q         <= '0;
         write_reg_q   <= '0;
         reg2_q        <= '0;
         mem_bus_q     <= '0;
         wb_bus_q      <= '0;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_reg2      <= '0;
         out_write_reg <= '0;
         out_mem_bus   <= '0;
         out_wb_bus    <= '0;
      end else begin
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_reg2      <= '0;
         out_write_reg <= '0;
         out_mem_bus   <= '0;
         out_wb_bus    <= '0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (in_md_op == OP_PASS) begin
                     out_valid     <= 1'b1;
                     out_result    <= in_alu_result;
                     out_reg2      <= in_reg2;
                     out_write_reg <= in_write_reg;
                     out_mem_bus   <= in_mem_bus;
                     out_wb_bus    <= in_wb_bus;
                  end else begin
                     op_q        <= in_md_op;
                     count       <= CNT_W'(LEN_DATA);
                     acc_q       <= '0;
                     opa_q       <= in_a;
                     opb_q       <= in_b;
                     write_reg_q <= in_write_reg;
                     reg2_q      <= in_reg2;
                     mem_bus_q   <= in_mem_bus;
                     wb_bus_q    <= in_wb_bus;
                  end
               end
            end
            BUSY: begin
               if (flush) begin
                  count <= '0;
               end else begin
                  count <= count - CNT_W'(1);
                  if (op_q == OP_MULU) begin
                     acc_q <= mul_acc_next;
                     opa_q <= {opa_q[LEN_DATA-2:0], 1'b0};
                     opb_q <= {1'b0, opb_q[LEN_DATA-1:1]};
                  end else begin
                     acc_q <= rem_next;
                     opa_q <= quo_next;
                  end
                  if (last_iter) begin
                     out_valid     <= 1'b1;
                     out_result    <= final_result;
                     out_reg2      <= reg2_q;
                     out_write_reg <= write_reg_q;
                     out_mem_bus   <= mem_bus_q;
                     out_wb_bus    <= wb_bus_q;
                  end
               end
            end
            default: begin
               count <= '0;
            end
         endcase
      end
   end

   // Performance counter. It counts each cycle that stall is high, and stops
   // at all ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_busy_cycles <= '0;
      end else if (stall && (out_busy_cycles != 16'hFFFF)) begin
         out_busy_cycles <= out_busy_cycles + 16'd1;
      end
   end

endmodule

// File: doc/ex_mem_muldiv.md
Name: ex_mem_muldiv

Overview:
Parametrised EX/MEM pipeline latch for the MIPS pipeline. It adds an iterative multi-cycle multiply/divide unit to the single-cycle ALU path. Single-cycle results pass through the latch with one cycle of latency. MULTU/DIVU/REMU run for LEN_DATA iterations, and during that time `stall` holds the upstream pipeline and bubbles are sent toward MEM.

Parameters:
LEN_DATA, 32, datapath width (even, ≥4)
NUM_BITS, 5, register-address width
LEN_WB_BUS, 2, write-back control bus width
LEN_MEM_BUS, 9, memory control bus width

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  instruction present in EX this cycle
in_md_op  in  2  00 = pass in_alu_result; 01 = MULTU (low LEN_DATA bits); 10 = DIVU quotient; 11 = REMU remainder
in_alu_result  in  LEN_DATA  single-cycle ALU result (already forwarded)
in_a  in  LEN_DATA  mul/div operand A (dividend / multiplicand)
in_b  in  LEN_DATA  mul/div operand B (divisor / multiplier)
in_write_reg  in  NUM_BITS  destination register
in_reg2  in  LEN_DATA  store data
in_mem_bus  in  LEN_MEM_BUS  memory control
in_wb_bus  in  LEN_WB_BUS  write-back control
flush  in  1  kill instruction in EX / abort mul/div
stall  out  1  hold IF/ID/ID_EX; combinational: 1 iff state==BUSY
out_valid  out  1  result registers hold a valid instruction
out_result  out  LEN_DATA  ALU or mul/div result
out_reg2  out  LEN_DATA  latched store data
out_write_reg  out  NUM_BITS  latched destination
out_mem_bus  out  LEN_MEM_BUS  latched memory control
out_wb_bus  out  LEN_WB_BUS  latched write-back control
out_busy_cycles  out  16  saturating count of stall cycles since reset (performance counter)

Behaviour:
- Reset (sync): all outputs 0, state = IDLE, iteration counter = 0, internal operand/accumulator registers = 0. Reset has priority over flush and in_valid. Reset mid-BUSY aborts the operation; stall = 0 the following cycle.
- FSM states: IDLE, BUSY.
- IDLE, flush=1: out_valid = 0 and all out_* buses = 0 next edge. The input is not accepted, and flush wins over in_valid.
- IDLE, in_valid=1, in_md_op=00: at the next edge, latch in_alu_result→out_result, and latch in_reg2, in_write_reg, in_mem_bus, in_wb_bus. Set out_valid = 1. Latency is 1 cycle.
- IDLE, in_valid=1, in_md_op≠00: at the accepting edge E0, capture operands, in_write_reg, in_reg2, and both control buses internally. Set counter = LEN_DATA and go to BUSY. At E0, out_valid = 0 and out_mem_bus = out_wb_bus = 0 (a bubble).
- IDLE, in_valid=0: bubble; out_valid = 0 and control buses = 0.
- BUSY:
  - One iteration per cycle; counter decrements.
  - Inputs are ignored because upstream is stalled and holds them.
  - Output registers keep producing bubbles: out_valid = 0, control buses = 0.
  - On the edge where counter goes 1→0, write the final result and the captured fields to the outputs, set out_valid = 1, and return to IDLE. This is edge E_LEN_DATA.
  - stall is high for exactly LEN_DATA cycles.
- MULTU: shift-add on unsigned operands; result = (A·B) mod 2^LEN_DATA.
- DIVU/REMU: restoring division, unsigned. B=0 gives quotient = all ones and remainder = A; no exception, same latency.
- flush while BUSY: abort and go to IDLE next edge. The result is never written, out_valid stays 0, and stall = 0 from the next cycle. in_valid in that same cycle is not accepted.
- out_busy_cycles increments on each cycle with stall=1 and saturates at 16'hFFFF.
- No back-to-back hazard: an instruction presented in the cycle after return to IDLE is accepted normally.

Test Plan:
- Reset, then in_valid with md_op=00, alu_result=0x1234, write_reg=5 → next edge: out_result=0x1234, out_write_reg=5, out_valid=1, stall=0.
- MULTU A=7, B=6 (LEN_DATA=32) → stall=1 for 32 cycles and out_valid=0 throughout. At edge E32: out_result=42, out_valid=1, then stall=0 and out_busy_cycles=32.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU 0xFFFFFFFF/1 → 0xFFFFFFFF; each with 32-cycle stall.
- DIVU 9/0 → quotient 0xFFFFFFFF; REMU 9/0 → 9; latency unchanged.
- Start MULTU, assert flush at BUSY cycle 10 → stall=0 next cycle, out_valid never 1, next md_op=00 instruction latches normally.
- Start DIVU, assert reset at BUSY cycle 5 → next edge: all outputs 0, stall=0, out_busy_cycles=0.
